btn_cmd_decoder: RTL and testbench
==================================

Name: btn_cmd_decoder

Overview:
- Consumer side of the four debounced button levels: btn_salud, btn_hambre, btn_reset, btn_test.
- Converts the levels into discrete game commands for the main pet FSM:
  - heal and feed: rising edge, with optional auto-repeat while held.
  - reset and test: long-press only.
  - test-mode toggle.
- Presents commands over a 1-deep valid/ready interface and flags lost commands.

Parameters:
- HOLD_RST, 250000000, consecutive high cycles on btn_reset needed to fire RESET (5 s at 50 MHz); must be >=2.
- HOLD_TST, 250000000, consecutive high cycles on btn_test needed to fire TEST toggle; must be >=2.
- REPEAT, 25000000, auto-repeat period in cycles for held heal/feed; 0 disables repeat.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_salud  input  1  debounced heal button level.
- btn_hambre  input  1  debounced feed button level.
- btn_reset  input  1  debounced reset button level.
- btn_test  input  1  debounced test button level.
- cmd_ready  input  1  game FSM accepts cmd_code this cycle.
- cmd_valid  output  1  command pending.
- cmd_code  output  3  1=HEAL, 2=FEED, 3=RESET_GAME, 4=TEST_TOGGLE; 0 when cmd_valid=0.
- test_mode  output  1  current test-mode level.
- overrun  output  1  sticky: at least one event was dropped.

Behaviour:
- Reset (reset=1 at a clk edge):
  - cmd_valid=0, cmd_code=0, test_mode=0, overrun=0.
  - All counters cleared. All four per-button FSMs go to WAIT_REL.
  - Reset asserted mid-hold or with a command pending discards all state.
- Per-button FSM states: WAIT_REL, IDLE, HELD. Inputs are sampled at each posedge.
  - WAIT_REL -> IDLE when input sampled 0. A button held through reset never fires until released.
  - IDLE -> HELD when input sampled 1; counter is loaded to 1.
  - HELD -> IDLE when input sampled 0; counter is cleared.
- Heal/feed:
  - Event on the IDLE->HELD transition.
  - With REPEAT>0, further events on the sample where the counter reaches 1+k*REPEAT (k>=1) while still high.
  - The counter wraps back so repeats continue indefinitely.
- Reset/test:
  - Event when the counter reaches HOLD_x while high. FSM then moves to WAIT_REL, so there is exactly one event per press.
  - Release before HOLD_x produces no event and no partial effect.
  - Counter width is clog2(max(HOLD_RST,HOLD_TST,REPEAT)+1); no overflow is possible.
- Event latency: the event is registered at the same edge that samples the qualifying input. cmd_valid/cmd_code are visible after that edge.
  - For heal, input high at edge N gives cmd_valid=1 in cycle N+1.
- Side effects take effect at the event edge, independent of the handshake:
  - TEST event toggles test_mode.
  - RESET event forces test_mode=0. If RESET and TEST fire on the same edge, test_mode=0.
- Priority when several events occur on one edge: RESET_GAME > TEST_TOGGLE > HEAL > FEED. Only the winner is a candidate; losers are dropped and set overrun.
- Output register:
  - A transfer occurs on an edge with cmd_valid=1 and cmd_ready=1.
  - Candidate present and (cmd_valid=0 or transfer): load the candidate; cmd_valid=1.
  - Transfer with no candidate: cmd_valid=0, cmd_code=0.
  - Candidate present while cmd_valid=1 and cmd_ready=0: candidate dropped, overrun=1; the held command is unchanged.
  - cmd_code is stable while cmd_valid=1 and cmd_ready=0.
  - cmd_ready is ignored while cmd_valid=0.
- overrun clears only on reset.

Test Plan (HOLD_RST=8, HOLD_TST=6, REPEAT=4, cmd_ready=1 unless stated):
- Heal pulse: btn_salud high for 2 cycles starting at edge 10 -> cmd_valid=1, cmd_code=1 only in cycle 11. No repeat. overrun=0.
- Feed auto-repeat: btn_hambre held for 12 cycles from edge 20 -> cmd_code=2 events at edges 20, 24, 28; exactly 3 single-cycle valids.
- Reset long-press:
  - btn_reset high 7 cycles -> no command.
  - Then high for 20 cycles with test_mode=1 -> one cmd_code=3 at the 8th high sample; test_mode=0; no second event before release.
- Test toggle and held-through-reset:
  - btn_test held 6 cycles -> cmd_code=4, test_mode 0->1.
  - Assert reset while btn_test stays high 10 more cycles, then release -> no event and test_mode=0 until the next full press.
- Back-pressure: cmd_ready=0, heal press then feed press -> cmd_code holds 1, feed dropped, overrun=1. Raising cmd_ready -> single transfer of code 1, then cmd_valid=0.
- Simultaneous: btn_salud and btn_hambre rise on the same edge -> cmd_code=1, overrun=1.

Source files
------------

// File: rtl/btn_cmd_decoder.sv
// Debounced button levels -> HEAL/FEED/RESET_GAME/TEST_TOGGLE commands; events appear the cycle after the qualifying sample.
// 1-deep output register: a new event while a command is stalled (cmd_ready=0) is dropped and sets sticky overrun.
module btn_cmd_decoder #(
  parameter int HOLD_RST = 250000000,
  parameter int HOLD_TST = 250000000,
  parameter int REPEAT   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_salud,
  input  logic       btn_hambre,
  input  logic       btn_reset,
  input  logic       btn_test,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       test_mode,
  output logic       overrun
);

  localparam int MAX_A = (HOLD_RST > HOLD_TST) ? HOLD_RST : HOLD_TST;
  localparam int MAX_C = (MAX_A > REPEAT) ? MAX_A : REPEAT;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_HEAL  = 3'd1;
  localparam logic [2:0] CODE_FEED  = 3'd2;
  localparam logic [2:0] CODE_RESET = 3'd3;
  localparam logic [2:0] CODE_TEST  = 3'd4;

  typedef enum logic [1:0] {WAIT_REL, IDLE, HELD} bstate_t;

  // Index 0/1 are edge-triggered (heal/feed), 2/3 are long-press (reset/test).
  logic [3:0]    btn;
  bstate_t       st_q  [4];
  bstate_t       st_d  [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [CW:0]   inc   [4];
  logic [3:0]    ev;
  logic          cand_vld;
  logic [2:0]    cand_code;
  logic          multi_ev;
  logic          xfer;

  assign btn = {btn_test, btn_reset, btn_hambre, btn_salud};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      ev[i]    = 1'b0;
      inc[i]   = {1'b0, cnt_q[i]} + {{CW{1'b0}}, 1'b1};
      case (st_q[i])
        WAIT_REL: if (!btn[i]) st_d[i] = IDLE;
        IDLE: begin
          if (btn[i]) begin
            st_d[i]  = HELD;
            cnt_d[i] = CW'(1);
            ev[i]    = (i < 2);
          end
        end
        HELD: begin
          if (!btn[i]) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else if (i < 2) begin
            // Counter cycles 1..REPEAT so repeats continue for as long as the button is held.
            if (REPEAT > 0) begin
              if (inc[i] == (CW+1)'(REPEAT + 1)) begin
                ev[i]    = 1'b1;
                cnt_d[i] = CW'(1);
              end else begin
                cnt_d[i] = inc[i][CW-1:0];
              end
            end
          end else if (inc[i] == (CW+1)'((i == 2) ? HOLD_RST : HOLD_TST)) begin
            ev[i]    = 1'b1;
            st_d[i]  = WAIT_REL;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = inc[i][CW-1:0];
          end
        end
        default: st_d[i] = WAIT_REL;
      endcase
    end
  end

  always_comb begin
    cand_vld  = 1'b1;
    cand_code = CODE_NONE;
    if (ev[2])      cand_code = CODE_RESET;
    else if (ev[3]) cand_code = CODE_TEST;
    else if (ev[0]) cand_code = CODE_HEAL;
    else if (ev[1]) cand_code = CODE_FEED;
    else            cand_vld  = 1'b0;
  end

  assign multi_ev = ((ev & (ev - 4'd1)) != 4'd0);
  assign xfer     = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= WAIT_REL;
        cnt_q[i] <= '0;
      end
      cmd_valid <= 1'b0;
      cmd_code  <= CODE_NONE;
      test_mode <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      if (ev[2])      test_mode <= 1'b0;
      else if (ev[3]) test_mode <= ~test_mode;
      if (cand_vld && (!cmd_valid || xfer)) begin
        cmd_valid <= 1'b1;
        cmd_code  <= cand_code;
      end else if (xfer) begin
        cmd_valid <= 1'b0;
        cmd_code  <= CODE_NONE;
      end
      if (multi_ev || (cand_vld && cmd_valid && !cmd_ready)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_btn_cmd_decoder.sv
// Bench for btn_cmd_decoder: directed long-press/repeat/back-pressure scenarios, then random
// button activity, all compared every cycle against a run-length reference model.
module tb_btn_cmd_decoder;

  localparam int HR = 8;
  localparam int HT = 6;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_salud = 1'b0;
  logic       btn_hambre = 1'b0;
  logic       btn_reset = 1'b0;
  logic       btn_test = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       test_mode;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btn_cmd_decoder #(.HOLD_RST(HR), .HOLD_TST(HT), .REPEAT(RP)) dut (
    .clk(clk), .reset(reset),
    .btn_salud(btn_salud), .btn_hambre(btn_hambre), .btn_reset(btn_reset), .btn_test(btn_test),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .test_mode(test_mode), .overrun(overrun)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: a button is "armed" once seen low; run counts consecutive armed high samples.
  bit armed [4];
  int run   [4];
  bit exp_valid, exp_tm, exp_ov, started;
  int exp_code;

  always @(posedge clk) begin
    bit lv [4];
    bit e  [4];
    int hits, cand;
    started = 1'b1;
    lv[0] = btn_salud; lv[1] = btn_hambre; lv[2] = btn_reset; lv[3] = btn_test;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        armed[i] = 1'b0;
        run[i]   = 0;
      end
      exp_valid = 1'b0; exp_code = 0; exp_tm = 1'b0; exp_ov = 1'b0;
    end else begin
      hits = 0;
      for (int i = 0; i < 4; i++) begin
        e[i] = 1'b0;
        if (!lv[i]) begin
          armed[i] = 1'b1;
          run[i]   = 0;
        end else if (armed[i]) begin
          run[i]++;
          if (i < 2) begin
            e[i] = (run[i] == 1) || (RP > 0 && (run[i] - 1) % RP == 0);
          end else if (run[i] == ((i == 2) ? HR : HT)) begin
            e[i] = 1'b1; armed[i] = 1'b0; run[i] = 0;
          end
        end
        if (e[i]) hits++;
      end
      cand = e[2] ? 3 : e[3] ? 4 : e[0] ? 1 : e[1] ? 2 : 0;
      if (e[2]) exp_tm = 1'b0;
      else if (e[3]) exp_tm = !exp_tm;
      if (hits > 1) exp_ov = 1'b1;
      if (exp_valid && cmd_ready) begin
        exp_valid = 1'b0; exp_code = 0;
      end
      if (cand != 0) begin
        if (!exp_valid) begin
          exp_valid = 1'b1; exp_code = cand;
        end else begin
          exp_ov = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_cmd_valid", cmd_valid, exp_valid);
      check("model_cmd_code",  cmd_code,  exp_code);
      check("model_test_mode", test_mode, exp_tm);
      check("model_overrun",   overrun,   exp_ov);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn_test, btn_reset, btn_hambre, btn_salud} = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] mask;
    int          nv;
    logic [3:0]  lv;

    tick(); tick();
    check("reset_valid", cmd_valid, 0);
    check("reset_code",  cmd_code,  0);
    check("reset_tm",    test_mode, 0);
    check("reset_ov",    overrun,   0);
    reset = 1'b0;
    tick(); tick();

    // Heal pulse: two high samples, exactly one command.
    btn_salud = 1'b1; tick();
    check("heal_valid", cmd_valid, 1);
    check("heal_code",  cmd_code,  1);
    tick();
    check("heal_no_repeat", cmd_valid, 0);
    btn_salud = 1'b0; tick();
    check("heal_ov", overrun, 0);

    // Feed auto-repeat: 12 high samples -> events at samples 1, 5, 9.
    btn_hambre = 1'b1;
    mask = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      mask[k] = cmd_valid && (cmd_code == 3'd2);
    end
    check("feed_repeat_mask", mask, 12'h111);
    btn_hambre = 1'b0; tick(); tick();

    // Reset short press: no command.
    btn_reset = 1'b1; nv = 0;
    for (int k = 0; k < 7; k++) begin tick(); nv += cmd_valid; end
    check("rst_short_none", nv, 0);
    btn_reset = 1'b0; tick();

    // Test toggle on 6th sample; extra hold gives nothing.
    btn_test = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("tst_pre_tm", test_mode, 0);
    tick();
    check("tst_code", cmd_code, 4);
    check("tst_tm", test_mode, 1);
    tick(); tick();
    check("tst_once", cmd_valid, 0);
    btn_test = 1'b0; tick();

    // Reset long press: one RESET_GAME at 8th sample, clears test_mode.
    btn_reset = 1'b1; nv = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      nv += cmd_valid;
      if (k == 7) begin
        check("rst_code", cmd_code, 3);
        check("rst_tm", test_mode, 0);
      end
    end
    check("rst_single", nv, 1);
    btn_reset = 1'b0; tick();

    // Test held through reset: no event until a fresh press.
    btn_test = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("thr_tm_on", test_mode, 1);
    do_reset();
    check("thr_reset_tm", test_mode, 0);
    nv = 0;
    for (int k = 0; k < 10; k++) begin tick(); nv += cmd_valid; end
    check("thr_no_event", nv, 0);
    check("thr_tm_off", test_mode, 0);
    btn_test = 1'b0; tick();
    btn_test = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("thr_repress_code", cmd_code, 4);
    check("thr_repress_tm", test_mode, 1);
    btn_test = 1'b0; tick();

    // Back-pressure: held heal survives, feed dropped.
    tick();
    cmd_ready = 1'b0;
    btn_salud = 1'b1; tick();
    btn_salud = 1'b0; tick();
    btn_hambre = 1'b1; tick();
    check("bp_code_held", cmd_code, 1);
    check("bp_ov", overrun, 1);
    btn_hambre = 1'b0; tick();
    check("bp_still_valid", cmd_valid, 1);
    cmd_ready = 1'b1; tick();
    check("bp_drained", cmd_valid, 0);
    check("bp_code_zero", cmd_code, 0);

    // Simultaneous heal+feed: heal wins, overrun set.
    do_reset();
    tick();
    btn_salud = 1'b1; btn_hambre = 1'b1; tick();
    check("sim_code", cmd_code, 1);
    check("sim_ov", overrun, 1);
    set_btns(4'b0000); tick();

    // Random phase: per-button toggles, random ready, occasional reset.
    lv = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) lv[i] = ~lv[i];
      set_btns(lv);
      cmd_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
